// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI-style copy/read initiator.
package axi_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 64;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      RD_CAP  = 3'd3,
      WR_SEL  = 3'd4,
      WR_ADDR = 3'd5,
      WR_DATA = 3'd6,
      FIN     = 3'd7
   } axi_state_e;

   // States that wait on a responder handshake and are therefore timed.
   function automatic logic is_wait_state(axi_state_e s);
      return s inside {RD_ADDR, RD_DATA, WR_ADDR, WR_DATA};
   endfunction

endpackage

// File: rtl/axi_wait_timer.sv
// Saturating per-phase wait counter; expired once the count reaches limit-1.
module axi_wait_timer
   import axi_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count >= (limit - 1'b1));

endmodule

// File: rtl/axi_initiator.sv
// Single-outstanding initiator: indexed read, or copy-write (target selected
// via a one-cycle AR beat, then AW/W carrying the copy-source index).
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | accepting a command, all master strobes low
// RD_ADDR | arvalid high, waiting for arready
// RD_DATA | arvalid + rready high, waiting for rvalid
// RD_CAP  | responder data now registered, capture into rd_result
// WR_SEL  | one-cycle arvalid to load the write target address
// WR_ADDR | awvalid high, waiting for awready
// WR_DATA | awvalid + wvalid high with source index, waiting for wready
// FIN     | one-cycle done pulse
module axi_initiator
   import axi_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic       cmd_write,
   input  logic [3:0] cmd_addr,
   input  logic [3:0] cmd_src,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rd_result,
   output logic       ms_arvalid,
   output logic [3:0] ms_araddr,
   input  logic       sm_arready,
   output logic       ms_rready,
   input  logic       sm_rvalid,
   input  logic [7:0] sm_rdata,
   output logic       ms_awvalid,
   input  logic       sm_awready,
   output logic       ms_wvalid,
   output logic [3:0] ms_wdata,
   input  logic       sm_wready
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   axi_state_e state;
   axi_state_e nxt;
   logic [3:0] addr_q;
   logic [3:0] src_q;
   logic       write_q;
   logic       hs;
   logic       timed_out;
   logic       expired;
   logic       tmr_clear;
   logic       tmr_enable;

   always_comb begin
      hs = 1'b0;
      case (state)
         RD_ADDR: hs = sm_arready;
         RD_DATA: hs = sm_rvalid;
         WR_ADDR: hs = sm_awready;
         WR_DATA: hs = sm_wready;
         default: hs = 1'b0;
      endcase
   end

   // A handshake takes priority over expiry on the same cycle.
   always_comb begin
      nxt       = state;
      timed_out = 1'b0;
      case (state)
         IDLE:    if (cmd_valid) nxt = cmd_write ? WR_SEL : RD_ADDR;
         RD_ADDR: if (hs) nxt = RD_DATA;
         RD_DATA: if (hs) nxt = RD_CAP;
         RD_CAP:  nxt = FIN;
         WR_SEL:  nxt = WR_ADDR;
         WR_ADDR: if (hs) nxt = WR_DATA;
         WR_DATA: if (hs) nxt = FIN;
         FIN:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (is_wait_state(state) && !hs && expired) begin
         nxt       = FIN;
         timed_out = 1'b1;
      end
   end

   assign tmr_clear  = (nxt != state);
   assign tmr_enable = is_wait_state(state) && !hs;

   axi_wait_timer #(.W(CNT_W)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (tmr_clear),
      .enable  (tmr_enable),
      .limit   (LIMIT),
      .expired (expired)
   );

   // Outputs are decoded from the next state so they are registered and
   // line up with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr_q     <= '0;
         src_q      <= '0;
         write_q    <= 1'b0;
         cmd_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         rd_result  <= '0;
         ms_arvalid <= 1'b0;
         ms_araddr  <= '0;
         ms_rready  <= 1'b0;
         ms_awvalid <= 1'b0;
         ms_wvalid  <= 1'b0;
         ms_wdata   <= '0;
      end else begin
         state      <= nxt;
         cmd_ready  <= (nxt == IDLE);
         busy       <= (nxt != IDLE);
         done       <= (nxt == FIN);
         ms_arvalid <= nxt inside {RD_ADDR, RD_DATA, WR_SEL};
         ms_rready  <= (nxt == RD_DATA);
         ms_awvalid <= nxt inside {WR_ADDR, WR_DATA};
         ms_wvalid  <= (nxt == WR_DATA);
         ms_wdata   <= (nxt == WR_DATA) ? src_q : 4'h0;

         if (nxt == IDLE) begin
            ms_araddr <= 4'h0;
         end else if (state == IDLE) begin
            ms_araddr <= cmd_addr;
         end else begin
            ms_araddr <= addr_q;
         end

         if (state == IDLE && cmd_valid) begin
            addr_q  <= cmd_addr;
            src_q   <= cmd_src;
            write_q <= cmd_write;
            err     <= 1'b0;
         end

         if (timed_out) begin
            err <= 1'b1;
         end

         if (state == RD_CAP && !write_q) begin
            rd_result <= sm_rdata;
         end
      end
   end

endmodule

// File: tb/tb_axi_initiator.sv
// Directed + randomized bench for axi_initiator against a memory responder
// and an arithmetic latency/outcome model.
module tb_axi_initiator;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid, cmd_write;
   logic [3:0] cmd_addr, cmd_src;
   logic       cmd_ready, busy, done, err;
   logic [7:0] rd_result;
   logic       ms_arvalid, sm_arready, ms_rready, sm_rvalid;
   logic [3:0] ms_araddr, ms_wdata;
   logic [7:0] sm_rdata;
   logic       ms_awvalid, sm_awready, ms_wvalid, sm_wready;

   int total = 0;
   int bad   = 0;

   logic [7:0] rsp_mem [16];
   logic [7:0] exp_mem [16];
   logic [7:0] exp_rd;
   logic [3:0] tgt = 4'h0;
   int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0;
   int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0;

   always #5 clk = ~clk;

   axi_initiator #(.TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_write  (cmd_write),
      .cmd_addr   (cmd_addr),
      .cmd_src    (cmd_src),
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .rd_result  (rd_result),
      .ms_arvalid (ms_arvalid),
      .ms_araddr  (ms_araddr),
      .sm_arready (sm_arready),
      .ms_rready  (ms_rready),
      .sm_rvalid  (sm_rvalid),
      .sm_rdata   (sm_rdata),
      .ms_awvalid (ms_awvalid),
      .sm_awready (sm_awready),
      .ms_wvalid  (ms_wvalid),
      .ms_wdata   (ms_wdata),
      .sm_wready  (sm_wready)
   );

   // Responder: each ready/valid rises after a programmable number of
   // waiting cycles; address 0 never accepts a write address.
   wire ar_ph = ms_arvalid && !ms_rready;
   wire aw_ph = ms_awvalid && !ms_wvalid;
   assign sm_arready = ar_ph && (ar_cnt == ar_dly);
   assign sm_rvalid  = ms_rready && (r_cnt == r_dly);
   assign sm_awready = aw_ph && (tgt != 4'h0) && (aw_cnt == aw_dly);
   assign sm_wready  = ms_wvalid && (w_cnt == w_dly);

   always @(posedge clk) begin
      ar_cnt <= ar_ph ? ar_cnt + 1 : 0;
      r_cnt  <= ms_rready ? r_cnt + 1 : 0;
      aw_cnt <= aw_ph ? aw_cnt + 1 : 0;
      w_cnt  <= ms_wvalid ? w_cnt + 1 : 0;
      if (ms_arvalid) tgt <= ms_araddr;
      if (ms_rready && sm_rvalid) sm_rdata <= rsp_mem[tgt];
      else                        sm_rdata <= 8'($urandom);
      if (ms_wvalid && sm_wready) rsp_mem[tgt] = rsp_mem[ms_wdata];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int phase_len(input int d);
      return (d >= TO) ? TO : d + 1;
   endfunction

   task automatic run(input bit wr, input logic [3:0] a, input logic [3:0] s,
                      input int ard, input int rd, input int awd, input int wd);
      int  n, rr, exp_lat, awe;
      bit  exp_err, addr_ok;
      exp_err = 1'b0;
      exp_lat = 1;
      if (!wr) begin
         exp_lat += phase_len(ard);
         if (ard >= TO) exp_err = 1'b1;
         else begin
            exp_lat += phase_len(rd);
            if (rd >= TO) exp_err = 1'b1;
            else begin
               exp_lat += 1;
               exp_rd = exp_mem[a];
            end
         end
      end else begin
         awe = (a == 4'h0) ? 1000 : awd;
         exp_lat += 1 + phase_len(awe);
         if (awe >= TO) exp_err = 1'b1;
         else begin
            exp_lat += phase_len(wd);
            if (wd >= TO) exp_err = 1'b1;
            else exp_mem[a] = exp_mem[s];
         end
      end

      ar_dly = ard; r_dly = rd; aw_dly = awd; w_dly = wd;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_src = s;
      @(negedge clk);
      n = 1;
      // Conflicting command while busy must be ignored.
      cmd_write = ~wr; cmd_addr = ~a; cmd_src = ~s;
      chk("busy_not_ready", cmd_ready, 1'b0);
      chk("araddr_latched", ms_araddr, a);
      rr = 0;
      addr_ok = 1'b1;
      while (!done && n < 4 * TO + 10) begin
         @(negedge clk);
         n++;
         cmd_valid = 1'b0;
         if (ms_rready) rr++;
         if (busy && ms_araddr !== a) addr_ok = 1'b0;
      end
      chk("done_seen", done, 1'b1);
      chk("latency", n, exp_lat);
      chk("err", err, exp_err);
      chk("rd_result", rd_result, exp_rd);
      chk("fin_quiet", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 4'h0);
      chk("araddr_hold", addr_ok, 1'b1);
      if (!wr && ard < TO) chk("rready_cycles", rr, phase_len(rd));
      @(negedge clk);
      chk("done_pulse", done, 1'b0);
      chk("idle_ready", cmd_ready, 1'b1);
      chk("idle_busy", busy, 1'b0);
      chk("idle_araddr", ms_araddr, 4'h0);
      chk("err_sticky", err, exp_err);
   endtask

   initial begin
      int n, dn;
      for (int i = 0; i < 16; i++) begin
         rsp_mem[i] = 8'($urandom);
         exp_mem[i] = rsp_mem[i];
      end
      rsp_mem[5] = 8'h49; exp_mem[5] = 8'h49;
      rsp_mem[7] = 8'h1F; exp_mem[7] = 8'h1F;
      exp_rd = 8'h00;

      reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_src = 4'h0;
      #3;
      chk("rst_ready", cmd_ready, 1'b1);
      chk("rst_busy_done_err", {busy, done, err}, 3'b000);
      chk("rst_rd_result", rd_result, 8'h00);
      chk("rst_ms", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, ms_araddr, ms_wdata}, 12'h000);
      @(negedge clk);
      reset = 1'b0;

      run(1'b0, 4'd5, 4'd0, 1, 1, 0, 0);
      chk("read5_value", rd_result, 8'h49);
      run(1'b1, 4'd3, 4'd7, 0, 0, 0, 1);
      run(1'b0, 4'd3, 4'd0, 0, 2, 0, 0);
      chk("read3_value", rd_result, 8'h1F);
      run(1'b1, 4'd0, 4'd4, 0, 0, 0, 0);
      run(1'b0, 4'd2, 4'd0, 0, 0, 0, 0);
      run(1'b0, 4'd6, 4'd0, 0, 255, 0, 0);
      run(1'b0, 4'd6, 4'd0, 0, 2, 0, 0);
      run(1'b0, 4'd8, 4'd0, 0, TO - 1, 0, 0);
      run(1'b0, 4'd9, 4'd0, TO, 0, 0, 0);
      run(1'b1, 4'd10, 4'd5, 0, 0, TO - 1, 0);
      run(1'b1, 4'd11, 4'd3, 0, 0, 0, TO);
      run(1'b0, 4'd10, 4'd0, 0, 0, 0, 0);

      for (int k = 0; k < 24; k++) begin
         run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom_range(0, TO), $urandom_range(0, TO),
             $urandom_range(0, TO), $urandom_range(0, TO));
      end

      // Reset while a write sits in WR_DATA.
      ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 255;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd9; cmd_src = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!ms_wvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("reach_wdata", ms_wvalid, 1'b1);
      chk("wdata_src", ms_wdata, 4'd2);
      #2 reset = 1'b1;
      #1;
      chk("midrst_ms", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid, ms_araddr, ms_wdata}, 12'h000);
      chk("midrst_busy_ready", {busy, cmd_ready}, 2'b01);
      @(negedge clk);
      reset = 1'b0;
      exp_rd = 8'h00;
      dn = 0;
      repeat (TO + 4) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("no_done_after_rst", dn, 0);
      chk("rd_result_after_rst", rd_result, 8'h00);
      run(1'b0, 4'd9, 4'd0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
